// File: rtl/cop0_regfile.sv
// ---------------------------------------------------------------------------
// cop0_regfile
//
// Architectural CP0 register storage. Holds Status, Cause, EPC, ErrorEPC,
// BadVAddr and the Count/Compare timer. It also produces the registered
// interrupt request for the exception unit.
//
// Optional feature macro: COP0_TIMER_EN
//   defined   : Count, Compare, the Count divider and Cause.TI are built.
//   undefined : no timer storage; regs 9/11 read as 0 and TI is tied to 0.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   we/waddr/wdata      CP0 write port (mtc0 or ERET/EI/DI Status update)
//   raddr/rdata         combinational mfc0 read port (pre-write values)
//   exc_*               exception capture from the commit point
//   hw_int              level-sensitive external interrupt lines
//   status/cause/epc/error_epc   current architectural values
//   int_pending         registered interrupt request
// ---------------------------------------------------------------------------
module cop0_regfile #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic [5:0]  hw_int,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic [31:0] error_epc,
  output logic        int_pending
);

  // Writable Status bits: IE, EXL, ERL, IM[7:0], BEV, CU0
  localparam logic [31:0] STATUS_MASK  = 32'h1040_FF07;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0004;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_ERROREPC = 5'd30;

  logic [31:0] status_q, status_next;
  logic [31:0] epc_q, epc_next;
  logic [31:0] error_epc_q, error_epc_next;
  logic [31:0] badvaddr_q, badvaddr_next;
  logic        bd_q, bd_next;
  logic [4:0]  exc_code_q, exc_code_next;
  logic [1:0]  sw_ip_q, sw_ip_next;
  logic [5:0]  hw_int_q;
  logic        int_pending_q, int_pending_next;
  logic [7:0]  ip_q, ip_next;

  logic        ti, ti_next;
  logic [31:0] count_rd, compare_rd;

  // Exception capture has priority over the write port. EPC and BD are
  // frozen while EXL is already set so a nested exception keeps the
  // original return address.
  always_comb begin
    status_next    = status_q;
    epc_next       = epc_q;
    error_epc_next = error_epc_q;
    badvaddr_next  = badvaddr_q;
    bd_next        = bd_q;
    exc_code_next  = exc_code_q;
    sw_ip_next     = sw_ip_q;
    if (exc_valid) begin
      status_next[1] = 1'b1;
      exc_code_next  = exc_code;
      if (!status_q[1]) begin
        epc_next = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_next  = exc_bd;
      end
      if (exc_badvaddr_valid) begin
        badvaddr_next = exc_badvaddr;
      end
    end else if (we) begin
      case (waddr)
        REG_STATUS:   status_next    = wdata & STATUS_MASK;
        REG_CAUSE:    sw_ip_next     = wdata[9:8];
        REG_EPC:      epc_next       = wdata;
        REG_ERROREPC: error_epc_next = wdata;
        default:      ;
      endcase
    end
  end

  // The interrupt request is computed from the values being written this
  // edge, so it never lags the registers it depends on by more than a cycle.
  always_comb begin
    ip_next          = {hw_int[5] | ti_next, hw_int[4:0], sw_ip_next};
    int_pending_next = status_next[0] & ~status_next[1] & ~status_next[2] &
                       (|(status_next[15:8] & ip_next));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q      <= STATUS_RESET;
      epc_q         <= '0;
      error_epc_q   <= '0;
      badvaddr_q    <= '0;
      bd_q          <= 1'b0;
      exc_code_q    <= '0;
      sw_ip_q       <= '0;
      hw_int_q      <= '0;
      int_pending_q <= 1'b0;
    end else begin
      status_q      <= status_next;
      epc_q         <= epc_next;
      error_epc_q   <= error_epc_next;
      badvaddr_q    <= badvaddr_next;
      bd_q          <= bd_next;
      exc_code_q    <= exc_code_next;
      sw_ip_q       <= sw_ip_next;
      hw_int_q      <= hw_int;
      int_pending_q <= int_pending_next;
    end
  end

`ifdef COP0_TIMER_EN
  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [31:0] count_q, count_next;
  logic [31:0] compare_q, compare_next;
  logic [3:0]  div_q, div_next;
  logic        ti_q;
  logic        wr;

  assign wr = we & ~exc_valid;

  // A Count write reloads Count and restarts the divider and never raises
  // TI. Otherwise TI is raised only by an increment landing on Compare.
  // A Compare write always clears TI.
  always_comb begin
    count_next   = count_q;
    compare_next = compare_q;
    div_next     = div_q;
    ti_next      = ti_q;
    if (wr && (waddr == REG_COUNT)) begin
      count_next = wdata;
      div_next   = '0;
    end else if (div_q == DIV_LAST) begin
      div_next   = '0;
      count_next = count_q + 32'd1;
      if ((count_q + 32'd1) == compare_q) begin
        ti_next = 1'b1;
      end
    end else begin
      div_next = div_q + 4'd1;
    end
    if (wr && (waddr == REG_COMPARE)) begin
      compare_next = wdata;
      ti_next      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      div_q     <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_next;
      compare_q <= compare_next;
      div_q     <= div_next;
      ti_q      <= ti_next;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign ti_next    = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  assign ip_q = {hw_int_q[5] | ti, hw_int_q[4:0], sw_ip_q};

  assign status      = status_q;
  assign cause       = {bd_q, ti, 14'd0, ip_q, 1'b0, exc_code_q, 2'b00};
  assign epc         = epc_q;
  assign error_epc   = error_epc_q;
  assign int_pending = int_pending_q;

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_rd;
      REG_COMPARE:  rdata = compare_rd;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID;
      REG_ERROREPC: rdata = error_epc_q;
      default:      rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cop0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cop0_regfile
//
// Self-checking bench for cop0_regfile. A table of write/read-back vectors
// covers the register masks and read-only registers. Hand-written sequences
// cover exception capture, interrupts, the timer (when COP0_TIMER_EN is
// defined) and a mid-run reset.
// ---------------------------------------------------------------------------
module tb_cop0_regfile;

  localparam logic [31:0] PRID = 32'h0001_8000;
`ifdef COP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] error_epc;
  logic        int_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cop0_regfile #(.PRID(PRID), .COUNT_DIV(2)) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata),
    .exc_valid(exc_valid),
    .exc_code(exc_code),
    .exc_pc(exc_pc),
    .exc_bd(exc_bd),
    .exc_badvaddr_valid(exc_badvaddr_valid),
    .exc_badvaddr(exc_badvaddr),
    .hw_int(hw_int),
    .status(status),
    .cause(cause),
    .epc(epc),
    .error_epc(error_epc),
    .int_pending(int_pending)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_old;
    logic [31:0] exp_new;
    bit          chk_old;
  } vec_t;

  vec_t vecs[12];

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] ra);
    we    = w;
    waddr = wa;
    wdata = wd;
    raddr = ra;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic readReg(input logic [4:0] ra, input string name,
                         input logic [31:0] expected);
    raddr = ra;
    #1;
    checkOutput(name, rdata, expected);
  endtask

  task automatic writeReg(input logic [4:0] wa, input logic [31:0] wd);
    applyStimulus(1'b1, wa, wd, raddr);
    tick();
    we = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{5'd12, 32'hFFFF_FFFF, 32'h0040_0004, 32'h1040_FF07, 1'b1};
    vecs[1]  = '{5'd12, 32'h0000_0000, 32'h1040_FF07, 32'h0000_0000, 1'b1};
    vecs[2]  = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0300, 1'b1};
    vecs[3]  = '{5'd13, 32'h0000_0000, 32'h0000_0300, 32'h0000_0000, 1'b1};
    vecs[4]  = '{5'd14, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{5'd30, 32'h8000_0180, 32'h0000_0000, 32'h8000_0180, 1'b1};
    vecs[6]  = '{5'd8,  32'h1111_1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{5'd15, 32'h0000_0000, PRID,          PRID,          1'b1};
    vecs[8]  = '{5'd3,  32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{5'd11, 32'h0000_0100, 32'h0000_0000,
                 TIMER ? 32'h0000_0100 : 32'h0000_0000, 1'b1};
    vecs[10] = '{5'd9,  32'h0000_0040, 32'h0000_0000,
                 TIMER ? 32'h0000_0040 : 32'h0000_0000, 1'b0};
    vecs[11] = '{5'd14, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1};

    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr_valid = 1'b0; exc_badvaddr = '0; hw_int = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_status", status, 32'h0040_0004);
    checkOutput("rst_cause", cause, 32'h0);
    checkOutput("rst_epc", epc, 32'h0);
    checkOutput("rst_error_epc", error_epc, 32'h0);
    checkOutput("rst_int_pending", {31'd0, int_pending}, 32'h0);
    readReg(5'd8,  "rst_rd_badvaddr", 32'h0);
    readReg(5'd9,  "rst_rd_count", 32'h0);
    readReg(5'd11, "rst_rd_compare", 32'h0);
    readReg(5'd12, "rst_rd_status", 32'h0040_0004);
    readReg(5'd15, "rst_rd_prid", PRID);
    readReg(5'd30, "rst_rd_error_epc", 32'h0);

    // Write / read-back table: old value in the write cycle, new value after
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].addr);
      if (vecs[i].chk_old) begin
        checkOutput($sformatf("vec%0d_old", i), rdata, vecs[i].exp_old);
      end
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, vecs[i].addr);
      checkOutput($sformatf("vec%0d_new", i), rdata, vecs[i].exp_new);
    end

    // First exception from a delay slot with EXL clear
    exc_valid = 1'b1; exc_pc = 32'h8000_0104; exc_bd = 1'b1; exc_code = 5'd4;
    exc_badvaddr_valid = 1'b1; exc_badvaddr = 32'hBAD0_0000;
    tick();
    exc_valid = 1'b0; exc_badvaddr_valid = 1'b0;
    #1;
    checkOutput("exc1_epc", epc, 32'h8000_0100);
    checkOutput("exc1_cause", cause, 32'h8000_0010);
    checkOutput("exc1_status", status, 32'h0000_0002);
    readReg(5'd8, "exc1_badvaddr", 32'hBAD0_0000);

    // Nested exception: EPC and BD frozen, ExcCode updated, BadVAddr kept
    exc_valid = 1'b1; exc_pc = 32'h8000_0200; exc_bd = 1'b0; exc_code = 5'd12;
    exc_badvaddr = 32'h5555_5555;
    tick();
    exc_valid = 1'b0;
    #1;
    checkOutput("exc2_epc", epc, 32'h8000_0100);
    checkOutput("exc2_cause", cause, 32'h8000_0030);
    readReg(5'd8, "exc2_badvaddr", 32'hBAD0_0000);

    // Exception and write in the same cycle: the write is dropped
    writeReg(5'd12, 32'h0);
    exc_valid = 1'b1; exc_pc = 32'h8000_0300; exc_bd = 1'b0; exc_code = 5'd8;
    applyStimulus(1'b1, 5'd14, 32'h0000_1234, 5'd14);
    tick();
    exc_valid = 1'b0; we = 1'b0;
    #1;
    checkOutput("prio_epc", epc, 32'h8000_0300);
    checkOutput("prio_cause", cause, 32'h0000_0020);
    checkOutput("prio_status", status, 32'h0000_0002);

    // Hardware interrupt on IP2 with IM2 enabled
    writeReg(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    tick();
    checkOutput("hw_cause", cause, 32'h0000_0420);
    tick();
    checkOutput("hw_int_pending", {31'd0, int_pending}, 32'h1);
    hw_int = 6'b000010;
    tick(); tick();
    checkOutput("hw_masked_cause", cause, 32'h0000_0820);
    checkOutput("hw_masked_pending", {31'd0, int_pending}, 32'h0);
    writeReg(5'd12, 32'h0000_0405);
    hw_int = 6'b000001;
    tick(); tick();
    checkOutput("hw_erl_pending", {31'd0, int_pending}, 32'h0);
    hw_int = 6'b0;
    writeReg(5'd12, 32'h0);
    tick();

`ifdef COP0_TIMER_EN
    // Timer: Compare=5, Count written 0, TI on the 10th edge after the write
    writeReg(5'd12, 32'h0000_8001);
    writeReg(5'd11, 32'd5);
    writeReg(5'd9, 32'd0);
    repeat (9) tick();
    readReg(5'd9, "tmr_count_e9", 32'd4);
    checkOutput("tmr_ti_e9", {31'd0, cause[30]}, 32'h0);
    checkOutput("tmr_pending_e9", {31'd0, int_pending}, 32'h0);
    tick();
    readReg(5'd9, "tmr_count_e10", 32'd5);
    checkOutput("tmr_cause_e10", cause, 32'h4000_8020);
    tick();
    checkOutput("tmr_pending_e11", {31'd0, int_pending}, 32'h1);
    writeReg(5'd11, 32'h0000_1000);
    checkOutput("tmr_ti_cleared", {31'd0, cause[30]}, 32'h0);
    tick();
    checkOutput("tmr_pending_dropped", {31'd0, int_pending}, 32'h0);

    // Timer wrap: FFFF_FFFF -> 0 matches Compare=0
    writeReg(5'd12, 32'h0);
    writeReg(5'd11, 32'h0);
    writeReg(5'd9, 32'hFFFF_FFFF);
    tick();
    readReg(5'd9, "wrap_count_e1", 32'hFFFF_FFFF);
    checkOutput("wrap_ti_e1", {31'd0, cause[30]}, 32'h0);
    tick();
    readReg(5'd9, "wrap_count_e2", 32'h0);
    checkOutput("wrap_ti_e2", {31'd0, cause[30]}, 32'h1);

    // Writing Count equal to Compare never raises TI
    writeReg(5'd11, 32'h0000_0050);
    checkOutput("direct_ti_clear", {31'd0, cause[30]}, 32'h0);
    writeReg(5'd9, 32'h0000_0050);
    readReg(5'd9, "direct_count", 32'h0000_0050);
    checkOutput("direct_ti_write", {31'd0, cause[30]}, 32'h0);
    repeat (3) tick();
    checkOutput("direct_ti_later", {31'd0, cause[30]}, 32'h0);
`endif

    // Mid-run reset overrides write, exception and interrupt inputs
    exc_valid = 1'b1; exc_pc = 32'h8000_0400; hw_int = 6'h3F;
    applyStimulus(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12);
    reset = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0; exc_valid = 1'b0; hw_int = 6'h0;
    #1;
    checkOutput("mrst_status", status, 32'h0040_0004);
    checkOutput("mrst_epc", epc, 32'h0);
    checkOutput("mrst_cause", cause, 32'h0);
    checkOutput("mrst_pending", {31'd0, int_pending}, 32'h0);
    readReg(5'd30, "mrst_error_epc", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
